// File: rtl/picosoc_iomem_arbiter.sv
// Round-robin arbiter sharing one PicoSoC iomem slave port between two masters.
// A grant-cycle watchdog force-completes transactions the slave never acknowledges.
module picosoc_iomem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] TIMEOUT_RDATA  = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        m0_valid,
  input  logic [3:0]  m0_wstrb,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic [31:0] m0_rdata,
  output logic        m0_ready,
  input  logic        m1_valid,
  input  logic [3:0]  m1_wstrb,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic [31:0] m1_rdata,
  output logic        m1_ready,
  output logic        s_valid,
  output logic [3:0]  s_wstrb,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  input  logic [31:0] s_rdata,
  input  logic        s_ready,
  output logic        timeout_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] GNT0 = 2'd1;
  localparam logic [1:0] GNT1 = 2'd2;

  localparam bit          WD_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [15:0] WD_LAST = WD_EN ? 16'(TIMEOUT_CYCLES - 1) : 16'd0;

  logic [1:0]  state, state_next;
  logic        last, last_next;
  logic [15:0] wd_cnt;

  logic in_gnt, sel, cur_valid, wd_hit, done;

  assign in_gnt    = (state == GNT0) || (state == GNT1);
  assign sel       = (state == GNT1);
  assign cur_valid = sel ? m1_valid : m0_valid;
  // A slave acknowledge in the timeout cycle takes priority over the watchdog.
  assign wd_hit    = WD_EN && in_gnt && cur_valid && !s_ready && (wd_cnt == WD_LAST);
  assign done      = in_gnt && (s_ready || wd_hit || !cur_valid);

  always_comb begin
    state_next = state;
    last_next  = last;
    case (state)
      IDLE: begin
        if (m0_valid && m1_valid) state_next = last ? GNT0 : GNT1;
        else if (m0_valid)        state_next = GNT0;
        else if (m1_valid)        state_next = GNT1;
      end
      GNT0, GNT1: begin
        if (done) begin
          state_next = IDLE;
          last_next  = sel;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      last  <= 1'b1;
    end else begin
      state <= state_next;
      last  <= last_next;
    end
  end

  // Counter saturates so a disabled watchdog can never wrap.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      wd_cnt <= '0;
    else if (!in_gnt)
      wd_cnt <= '0;
    else if (!s_ready && (wd_cnt != 16'hFFFF))
      wd_cnt <= wd_cnt + 16'd1;
  end

  always_comb begin
    s_valid   = 1'b0;
    s_wstrb   = '0;
    s_addr    = '0;
    s_wdata   = '0;
    m0_ready  = 1'b0;
    m0_rdata  = '0;
    m1_ready  = 1'b0;
    m1_rdata  = '0;
    timeout_o = wd_hit;
    if (in_gnt) begin
      s_valid = cur_valid && !wd_hit;
      s_wstrb = sel ? m1_wstrb : m0_wstrb;
      s_addr  = sel ? m1_addr  : m0_addr;
      s_wdata = sel ? m1_wdata : m0_wdata;
      if (sel) begin
        m1_ready = s_ready || wd_hit;
        m1_rdata = wd_hit ? TIMEOUT_RDATA : s_rdata;
      end else begin
        m0_ready = s_ready || wd_hit;
        m0_rdata = wd_hit ? TIMEOUT_RDATA : s_rdata;
      end
    end
  end

endmodule

// File: tb/tb_picosoc_iomem_arbiter.sv
// Directed self-checking bench for picosoc_iomem_arbiter (watchdog set to 8 cycles).
module tb_picosoc_iomem_arbiter;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        m0_valid = 1'b0, m1_valid = 1'b0;
  logic [3:0]  m0_wstrb = '0, m1_wstrb = '0;
  logic [31:0] m0_addr = '0, m1_addr = '0, m0_wdata = '0, m1_wdata = '0;
  logic [31:0] m0_rdata, m1_rdata;
  logic        m0_ready, m1_ready;
  logic        s_valid;
  logic [3:0]  s_wstrb;
  logic [31:0] s_addr, s_wdata;
  logic [31:0] s_rdata = '0;
  logic        s_ready = 1'b0;
  logic        timeout_o;

  int checks_total  = 0;
  int checks_passed = 0;

  picosoc_iomem_arbiter #(.TIMEOUT_CYCLES(8), .TIMEOUT_RDATA(32'hFFFF_FFFF)) dut (
    .clk(clk), .resetn(resetn),
    .m0_valid(m0_valid), .m0_wstrb(m0_wstrb), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_rdata(m0_rdata), .m0_ready(m0_ready),
    .m1_valid(m1_valid), .m1_wstrb(m1_wstrb), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_rdata(m1_rdata), .m1_ready(m1_ready),
    .s_valid(s_valid), .s_wstrb(s_wstrb), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_rdata(s_rdata), .s_ready(s_ready), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_total++;
    if (obs === exp) checks_passed++;
    else $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic applyStimulus(input logic v0, input logic v1, input logic rdy, input logic [31:0] rd);
    m0_valid = v0;
    m1_valid = v1;
    s_ready  = rdy;
    s_rdata  = rd;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_s_valid"}, {31'd0, s_valid}, 32'd0);
    checkOutput({tag, "_s_addr"}, s_addr, 32'd0);
    checkOutput({tag, "_m0_ready"}, {31'd0, m0_ready}, 32'd0);
    checkOutput({tag, "_m1_ready"}, {31'd0, m1_ready}, 32'd0);
    checkOutput({tag, "_timeout"}, {31'd0, timeout_o}, 32'd0);
  endtask

  task automatic doReset();
    resetn = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
    checkIdleOutputs("reset");
    tick();
    resetn = 1'b1;
    #1;
  endtask

  initial begin
    doReset();

    // single m0 read
    m0_wstrb = 4'h0; m0_addr = 32'h0200_0004;
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
    checkOutput("rd_c1_s_valid", {31'd0, s_valid}, 32'd0);
    tick();
    checkOutput("rd_c2_s_valid", {31'd0, s_valid}, 32'd1);
    checkOutput("rd_c2_s_addr", s_addr, 32'h0200_0004);
    checkOutput("rd_c2_m0_ready", {31'd0, m0_ready}, 32'd0);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h0000_01B2);
    checkOutput("rd_c3_m0_ready", {31'd0, m0_ready}, 32'd1);
    checkOutput("rd_c3_m0_rdata", m0_rdata, 32'h0000_01B2);
    checkOutput("rd_c3_m1_ready", {31'd0, m1_ready}, 32'd0);
    checkOutput("rd_c3_m1_rdata", m1_rdata, 32'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
    checkIdleOutputs("rd_c4");

    // simultaneous writes right after reset: m0 wins the first tie
    doReset();
    m0_wstrb = 4'h1; m0_addr = 32'h0200_0008; m0_wdata = 32'h41;
    m1_wstrb = 4'h1; m1_addr = 32'h0200_0008; m1_wdata = 32'h42;
    applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
    tick();
    checkOutput("tie_first_wdata", s_wdata, 32'h41);
    checkOutput("tie_first_wstrb", {28'd0, s_wstrb}, 32'h1);
    checkOutput("tie_c2_m1_ready", {31'd0, m1_ready}, 32'd0);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b1, 32'd0);
    checkOutput("tie_c3_m0_ready", {31'd0, m0_ready}, 32'd1);
    checkOutput("tie_c3_m1_ready", {31'd0, m1_ready}, 32'd0);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
    checkOutput("tie_c4_idle", {31'd0, s_valid}, 32'd0);
    tick();
    checkOutput("tie_second_wdata", s_wdata, 32'h42);
    applyStimulus(1'b0, 1'b1, 1'b1, 32'd0);
    checkOutput("tie_c5_m1_ready", {31'd0, m1_ready}, 32'd1);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);

    // both masters saturate the bus: strict alternation starting with m0
    m0_wdata = 32'hA0; m1_wdata = 32'hA1;
    applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
    for (int i = 0; i < 6; i++) begin
      for (int w = 0; w < 4 && !s_valid; w++) tick();
      checkOutput("rr_grant_seen", {31'd0, s_valid}, 32'd1);
      checkOutput("rr_grant_order", s_wdata, (i % 2 == 0) ? 32'hA0 : 32'hA1);
      tick();
      applyStimulus(1'b1, 1'b1, 1'b1, 32'd0);
      checkOutput("rr_ready", {30'd0, m1_ready, m0_ready}, (i % 2 == 0) ? 32'd1 : 32'd2);
      tick();
      applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
    tick();

    // watchdog: m1 read with a silent slave
    m1_wstrb = 4'h0; m1_addr = 32'h0200_0010;
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h1234_0000);
    tick();
    for (int k = 1; k < 8; k++) begin
      checkOutput("wd_pre_timeout", {31'd0, timeout_o}, 32'd0);
      checkOutput("wd_pre_s_valid", {31'd0, s_valid}, 32'd1);
      tick();
    end
    checkOutput("wd_m1_ready", {31'd0, m1_ready}, 32'd1);
    checkOutput("wd_m1_rdata", m1_rdata, 32'hFFFF_FFFF);
    checkOutput("wd_timeout", {31'd0, timeout_o}, 32'd1);
    checkOutput("wd_s_valid", {31'd0, s_valid}, 32'd0);
    tick();
    checkOutput("wd_next_idle", {31'd0, s_valid}, 32'd0);
    checkOutput("wd_next_timeout", {31'd0, timeout_o}, 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
    tick();

    // slave ready in the very cycle the watchdog would fire
    m0_wstrb = 4'h0; m0_addr = 32'h0200_0014;
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
    tick();
    for (int k = 1; k < 8; k++) tick();
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h1234_5678);
    checkOutput("race_m0_ready", {31'd0, m0_ready}, 32'd1);
    checkOutput("race_m0_rdata", m0_rdata, 32'h1234_5678);
    checkOutput("race_timeout", {31'd0, timeout_o}, 32'd0);
    checkOutput("race_s_valid", {31'd0, s_valid}, 32'd1);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
    tick();

    // asynchronous reset in the middle of a GNT0 transaction
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
    tick();
    m1_addr = 32'h0200_0020;
    applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
    checkOutput("rst_mid_granted", {31'd0, s_valid}, 32'd1);
    resetn = 1'b0;
    #1;
    checkIdleOutputs("rst_mid");
    applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
    tick();
    resetn = 1'b1;
    tick();
    checkOutput("rst_m1_granted", {31'd0, s_valid}, 32'd1);
    checkOutput("rst_m1_addr", s_addr, 32'h0200_0020);
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h0000_00AA);
    checkOutput("rst_m1_ready", {31'd0, m1_ready}, 32'd1);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
    tick();

    // m0 abandons its request mid-grant
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
    tick();
    checkOutput("abandon_granted", {31'd0, s_valid}, 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
    checkOutput("abandon_m0_ready", {31'd0, m0_ready}, 32'd0);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
    checkOutput("abandon_idle", {31'd0, s_valid}, 32'd0);
    tick();
    checkOutput("abandon_regrant", {31'd0, s_valid}, 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
